// File: rtl/axi_dma_rd_pkg.sv
// Shared AXI constants and FSM state encoding for the read DMA.
package axi_dma_rd_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'd2;
    localparam int         MAX_BURST   = 16;
    localparam int         BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/axi_dma_rd.sv
// AXI4 read DMA: splits a word transfer into INCR bursts of up to 16 beats
// that never cross a 4 KB page, one burst in flight at a time, and streams
// each returned word out with its running index.
module axi_dma_rd
    import axi_dma_rd_pkg::*;
#(
    parameter int BITS_TRANS     = 18,
    parameter int OUT_BITS_TRANS = 13,
    parameter int AXI_WIDTH_USER = 1,
    parameter int AXI_WIDTH_ID   = 4,
    parameter int AXI_WIDTH_AD   = 32,
    parameter int AXI_WIDTH_DA   = 32,
    parameter int AXI_WIDTH_DS   = AXI_WIDTH_DA / 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    output logic [AXI_WIDTH_AD-1:0]   M_ARADDR,
    output logic [AXI_WIDTH_ID-1:0]   M_ARID,
    output logic [7:0]                M_ARLEN,
    output logic [2:0]                M_ARSIZE,
    output logic [1:0]                M_ARBURST,
    output logic [1:0]                M_ARLOCK,
    output logic [3:0]                M_ARCACHE,
    output logic [2:0]                M_ARPROT,
    output logic [3:0]                M_ARQOS,
    output logic [3:0]                M_ARREGION,
    output logic [AXI_WIDTH_USER-1:0] M_ARUSER,
    input  logic                      M_RVALID,
    output logic                      M_RREADY,
    input  logic [AXI_WIDTH_DA-1:0]   M_RDATA,
    input  logic                      M_RLAST,
    input  logic [AXI_WIDTH_ID-1:0]   M_RID,
    input  logic [AXI_WIDTH_USER-1:0] M_RUSER,
    input  logic [1:0]                M_RRESP,
    input  logic                      start_dma,
    input  logic [BITS_TRANS-1:0]     num_trans,
    input  logic [AXI_WIDTH_AD-1:0]   start_addr,
    output logic [AXI_WIDTH_DA-1:0]   data_o,
    output logic                      data_vld_o,
    output logic [BITS_TRANS-1:0]     data_cnt_o,
    output logic                      done_o
);

    state_t                    state;
    logic [BITS_TRANS-1:0]     rem;    // words still to be requested
    logic [BITS_TRANS-1:0]     wcnt;   // words received so far this transfer
    logic [OUT_BITS_TRANS-1:0] bcnt;   // beats received in the current burst

    logic [OUT_BITS_TRANS-1:0] rcvd;
    logic [AXI_WIDTH_AD-1:0]   nxt_addr;
    logic [BITS_TRANS-1:0]     nxt_rem;
    logic [AXI_WIDTH_AD-1:0]   cand_addr;
    logic [BITS_TRANS-1:0]     cand_rem;
    logic [12:0]               w4k;
    logic [BITS_TRANS-1:0]     beats;
    logic [7:0]                cand_len;

    // Fixed AR attributes: single ID, 32-bit INCR, no lock/cache/QoS.
    assign M_ARID     = '0;
    assign M_ARSIZE   = SIZE_4B;
    assign M_ARBURST  = BURST_INCR;
    assign M_ARLOCK   = '0;
    assign M_ARCACHE  = '0;
    assign M_ARPROT   = '0;
    assign M_ARQOS    = '0;
    assign M_ARREGION = '0;
    assign M_ARUSER   = '0;

    // R-side ID/user/resp carry nothing useful for a single-ID master, and
    // only the page offset of the candidate address matters for splitting.
    logic unused_in;
    assign unused_in = ^{M_RID, M_RUSER, M_RRESP, cand_addr[AXI_WIDTH_AD-1:12]};

    // Next burst parameters: fresh from start inputs in IDLE, otherwise
    // advanced by the beats actually received (covers an early RLAST).
    always_comb begin
        rcvd     = bcnt + OUT_BITS_TRANS'(1);
        nxt_addr = M_ARADDR + (AXI_WIDTH_AD'(rcvd) << 2);
        nxt_rem  = (BITS_TRANS'(rcvd) >= rem) ? '0 : rem - BITS_TRANS'(rcvd);
        if (state == ST_IDLE) begin
            cand_addr = start_addr;
            cand_rem  = num_trans;
        end else begin
            cand_addr = nxt_addr;
            cand_rem  = nxt_rem;
        end
        w4k   = (13'(BOUNDARY_4K) - {1'b0, cand_addr[11:0]}) >> 2;
        beats = BITS_TRANS'(MAX_BURST);
        if (cand_rem < beats)
            beats = cand_rem;
        if (BITS_TRANS'(w4k) < beats)
            beats = BITS_TRANS'(w4k);
        cand_len = 8'(beats - BITS_TRANS'(1));
    end

    // Control FSM with all AXI and stream outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            rem        <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            M_ARVALID  <= 1'b0;
            M_ARADDR   <= '0;
            M_ARLEN    <= '0;
            M_RREADY   <= 1'b0;
            data_o     <= '0;
            data_vld_o <= 1'b0;
            data_cnt_o <= '0;
            done_o     <= 1'b0;
        end else begin
            data_vld_o <= 1'b0;
            done_o     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_dma) begin
                        M_ARADDR <= start_addr;
                        rem      <= num_trans;
                        wcnt     <= '0;
                        bcnt     <= '0;
                        if (num_trans != '0) begin
                            M_ARLEN   <= cand_len;
                            M_ARVALID <= 1'b1;
                            state     <= ST_ADDR;
                        end else begin
                            done_o <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        bcnt      <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (M_RVALID) begin
                        data_o     <= M_RDATA;
                        data_vld_o <= 1'b1;
                        data_cnt_o <= wcnt;
                        wcnt       <= wcnt + BITS_TRANS'(1);
                        bcnt       <= rcvd;
                        if (M_RLAST) begin
                            M_RREADY <= 1'b0;
                            M_ARADDR <= nxt_addr;
                            rem      <= nxt_rem;
                            if (nxt_rem == '0) begin
                                done_o <= 1'b1;
                                state  <= ST_DONE;
                            end else begin
                                M_ARLEN   <= cand_len;
                                M_ARVALID <= 1'b1;
                                state     <= ST_ADDR;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_rd.sv
// Self-checking bench for axi_dma_rd: behavioural AXI read slave over a
// computed memory image, plus a page/length model of the expected AR list.
module tb_axi_dma_rd;

    logic        clk = 1'b0;
    logic        rstn;
    logic        M_ARVALID, M_ARREADY;
    logic [31:0] M_ARADDR;
    logic [3:0]  M_ARID;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST, M_ARLOCK;
    logic [3:0]  M_ARCACHE;
    logic [2:0]  M_ARPROT;
    logic [3:0]  M_ARQOS, M_ARREGION;
    logic [0:0]  M_ARUSER;
    logic        M_RVALID, M_RREADY, M_RLAST;
    logic [31:0] M_RDATA;
    logic [3:0]  M_RID;
    logic [0:0]  M_RUSER;
    logic [1:0]  M_RRESP;
    logic        start_dma;
    logic [17:0] num_trans;
    logic [31:0] start_addr;
    logic [31:0] data_o;
    logic        data_vld_o;
    logic [17:0] data_cnt_o;
    logic        done_o;

    always #5 clk = ~clk;

    axi_dma_rd dut (
        .clk(clk), .rstn(rstn),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_ARID(M_ARID), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK), .M_ARCACHE(M_ARCACHE),
        .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARREGION(M_ARREGION),
        .M_ARUSER(M_ARUSER), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .M_RDATA(M_RDATA), .M_RLAST(M_RLAST), .M_RID(M_RID), .M_RUSER(M_RUSER),
        .M_RRESP(M_RRESP), .start_dma(start_dma), .num_trans(num_trans),
        .start_addr(start_addr), .data_o(data_o), .data_vld_o(data_vld_o),
        .data_cnt_o(data_cnt_o), .done_o(done_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory image: every word is a scramble of its byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    logic [31:0] exp_addr_q[$], obs_addr_q[$];
    logic [7:0]  exp_len_q[$],  obs_len_q[$];

    // Expected AR sequence from the splitting rule; cut>0 truncates the
    // first burst to that many beats, as an early RLAST would.
    task automatic build_exp(input logic [31:0] a0, input int n, input int cut);
        longint a = a0;
        int rem = n;
        bit first = 1'b1;
        exp_addr_q.delete();
        exp_len_q.delete();
        while (rem > 0) begin
            int b = 16;
            int w4k = int'((4096 - (a % 4096)) / 4);
            if (rem < b) b = rem;
            if (w4k < b) b = w4k;
            exp_addr_q.push_back(a[31:0]);
            exp_len_q.push_back(8'(b - 1));
            if (first && cut > 0 && cut < b) b = cut;
            first = 1'b0;
            a   += 4 * b;
            rem -= b;
        end
    endtask

    // Transfer context shared between the driver and the slave/monitor.
    logic [31:0] exp_base = '0;
    int          exp_n = 0, words = 0, done_cnt = 0, cut_k = 0, burst_idx = 0;
    bit          slow = 1'b0;

    // Slave/monitor state.
    bit          busy = 1'b0;
    int          ar_wait = 0, ar_delay = 0, beat = 0;
    logic [31:0] b_addr, hold_addr, last_data = '0;
    logic [7:0]  b_len, hold_len;
    bit          last;

    // AXI read slave plus output monitor; samples and drives on negedge.
    initial begin
        M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RLAST = 0;
        M_RID = 0; M_RUSER = 0; M_RRESP = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                busy = 0; ar_wait = 0; words = 0;
                M_ARREADY = 0; M_RVALID = 0; M_RLAST = 0;
                continue;
            end
            if (data_vld_o) begin
                chk("data_cnt", data_cnt_o, words);
                chk("data", data_o, mem_word(exp_base + 32'(4 * words)));
                last_data = data_o;
                words++;
            end else if (words > 0) begin
                chk("data_hold", data_o, last_data);
            end
            if (done_o) begin
                done_cnt++;
                if (exp_n > 0) begin
                    chk("done_with_last", data_vld_o, 1);
                    chk("done_words", words, exp_n);
                end
            end
            M_ARREADY = 0;
            if (M_ARVALID && busy)
                chk("one_outstanding", M_ARVALID, 0);
            if (M_ARVALID && !busy) begin
                if (ar_wait == 0) begin
                    hold_addr = M_ARADDR;
                    hold_len  = M_ARLEN;
                    ar_delay  = slow ? 5 : int'($urandom_range(0, 2));
                    chk("arsize", M_ARSIZE, 3'd2);
                    chk("arburst", M_ARBURST, 2'b01);
                    chk("arid", M_ARID, 0);
                end else begin
                    chk("araddr_stable", M_ARADDR, hold_addr);
                    chk("arlen_stable", M_ARLEN, hold_len);
                end
                if (ar_wait >= ar_delay) begin
                    M_ARREADY = 1;
                    obs_addr_q.push_back(M_ARADDR);
                    obs_len_q.push_back(M_ARLEN);
                    busy = 1; b_addr = M_ARADDR; b_len = M_ARLEN; beat = 0;
                    ar_wait = 0;
                end else begin
                    ar_wait++;
                end
            end
            M_RVALID = 0; M_RLAST = 0; M_RDATA = $urandom;
            if (busy && M_RREADY && $urandom_range(0, 1) == 1) begin
                M_RVALID = 1;
                M_RDATA  = mem_word(b_addr + 32'(4 * beat));
                last = (beat == int'(b_len)) ||
                       (cut_k > 0 && burst_idx == 0 && beat == cut_k - 1);
                M_RLAST = last;
                beat++;
                if (last) begin
                    busy = 0;
                    burst_idx++;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_arvalid"}, M_ARVALID, 0);
        chk({tag, "_araddr"}, M_ARADDR, 0);
        chk({tag, "_arlen"}, M_ARLEN, 0);
        chk({tag, "_rready"}, M_RREADY, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_vld"}, data_vld_o, 0);
        chk({tag, "_cnt"}, data_cnt_o, 0);
        chk({tag, "_done"}, done_o, 0);
    endtask

    task automatic run_xfer(input logic [31:0] a, input int n, input int cut,
                            input bit slow_ar, input bit inject, input bit abort);
        int  cyc = 0;
        bit  injected = 0;
        int  m;
        build_exp(a, n, cut);
        obs_addr_q.delete();
        obs_len_q.delete();
        words = 0; done_cnt = 0; burst_idx = 0;
        cut_k = cut; slow = slow_ar; exp_base = a; exp_n = n;
        @(negedge clk);
        start_dma = 1; num_trans = 18'(n); start_addr = a;
        @(negedge clk);
        start_dma = 0; num_trans = 18'($urandom); start_addr = $urandom;
        if (n == 0) begin
            chk("zero_done_next", done_o, 1);
            chk("zero_no_arvalid", M_ARVALID, 0);
        end
        while (done_cnt == 0 && cyc < 4000) begin
            if (abort && obs_addr_q.size() >= 2 && words >= 18) break;
            if (inject && !injected && M_RREADY) begin
                start_dma = 1; num_trans = 18'd7; start_addr = 32'h3000;
                injected = 1;
            end else begin
                start_dma = 0;
            end
            @(negedge clk);
            cyc++;
        end
        start_dma = 0;
        if (abort) begin
            rstn = 0;
            #1;
            check_zero("abort");
            repeat (3) begin
                @(negedge clk);
                chk("abort_done_low", done_o, 0);
            end
            chk("abort_no_done", done_cnt, 0);
            rstn = 1;
            return;
        end
        chk("timeout", cyc < 4000, 1);
        repeat (6) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("word_count", words, n);
        chk("ar_count", obs_addr_q.size(), exp_addr_q.size());
        if (inject) chk("inject_issued", injected, 1);
        m = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < m; i++) begin
            chk("ar_addr", obs_addr_q[i], exp_addr_q[i]);
            chk("ar_len", obs_len_q[i], exp_len_q[i]);
        end
        chk("idle_arvalid", M_ARVALID, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          n, cut;
        rstn = 0; start_dma = 0; num_trans = '0; start_addr = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1;
        repeat (2) @(negedge clk);
        chk("no_ar_without_start", M_ARVALID, 0);

        run_xfer(32'h0000_0000, 64, 0, 0, 0, 0);
        run_xfer(32'h0000_0100, 20, 0, 0, 0, 0);
        run_xfer(32'h0000_0FF0, 8, 0, 0, 0, 0);
        run_xfer(32'h0000_0200, 0, 0, 0, 0, 0);
        run_xfer(32'h0000_0400, 40, 0, 1, 1, 0);
        run_xfer(32'h0000_0000, 64, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        chk("post_abort_idle", M_ARVALID, 0);
        run_xfer(32'h0000_0800, 24, 0, 0, 0, 0);
        run_xfer(32'h0000_0000, 30, 5, 0, 0, 0);

        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1)
                a = 32'(4096 - 4 * $urandom_range(1, 20));
            else
                a = 32'(4 * $urandom_range(0, 1023));
            a   = a + 32'(4096 * $urandom_range(0, 15));
            n   = int'($urandom_range(0, 60));
            cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
            run_xfer(a, n, cut, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_dma_rd.md
AXI_DMA_RD -- requirements
Module: axi_dma_rd

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- BITS_TRANS, 18, width of num_trans and data_cnt_o.
- OUT_BITS_TRANS, 13, width of the internal burst counter.
- AXI_WIDTH_USER, 1, width of the user fields.
- AXI_WIDTH_ID, 4, width of the ID fields.
- AXI_WIDTH_AD, 32, address width.
- AXI_WIDTH_DA, 32, data width.
- AXI_WIDTH_DS, 4, AXI_WIDTH_DA/8.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rstn, in, 1, reset: asynchronous, active-low.
- M_ARVALID, out, 1, read address valid.
- M_ARREADY, in, 1, read address ready.
- M_ARADDR, out, AD, burst start address.
- M_ARID, out, ID, read ID, constant 0.
- M_ARLEN, out, 8, beats minus 1.
- M_ARSIZE, out, 3, constant 3'd2 (4 bytes).
- M_ARBURST, out, 2, constant 2'b01 (INCR).
- M_ARLOCK, out, 2, constant 0.
- M_ARCACHE, out, 4, constant 0.
- M_ARPROT, out, 3, constant 0.
- M_ARQOS, out, 4, constant 0.
- M_ARREGION, out, 4, constant 0.
- M_ARUSER, out, USER, constant 0.
- M_RVALID, in, 1, read data valid.
- M_RREADY, out, 1, read data ready.
- M_RDATA, in, DA, read data.
- M_RLAST, in, 1, last beat of burst.
- M_RID, in, ID, ignored.
- M_RUSER, in, USER, ignored.
- M_RRESP, in, 2, ignored.
- start_dma, in, 1, one-cycle start pulse.
- num_trans, in, BITS_TRANS, number of 32-bit words to read; sampled on start.
- start_addr, in, AD, byte address, 4-byte aligned; sampled on start.
- data_o, out, DA, received word.
- data_vld_o, out, 1, data_o valid, one cycle per word.
- data_cnt_o, out, BITS_TRANS, 0-based index of the word on data_o.
- done_o, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, DATA, DONE.
- IDLE -> ADDR on start_dma with num_trans>0.
- IDLE -> DONE on start_dma with num_trans==0.
- ADDR -> DATA on the AR handshake.
- DATA -> ADDR on RVALID&RREADY&RLAST when words remain.
- DATA -> DONE on RVALID&RREADY&RLAST when no words remain.
- DONE -> IDLE unconditionally.

REQ-004 start_dma SHALL be ignored outside IDLE.

REQ-005 Burst beats SHALL be min(16, words remaining, words left before the next 4 KB boundary).
- M_ARLEN = beats-1.
- Each next burst address = previous address + 4*beats.

REQ-006 Only one burst SHALL be outstanding at a time; at most one AR per ADDR visit.

REQ-007 M_ARVALID SHALL be 1 exactly in ADDR, and M_ARADDR/M_ARLEN SHALL stay stable while ARVALID=1 and ARREADY=0.

REQ-008 M_RREADY SHALL be 1 exactly in DATA, with no downstream backpressure.

REQ-009 On each R handshake, the next cycle SHALL have data_o=M_RDATA, data_vld_o=1, and data_cnt_o=beats received before this one; data_o and data_cnt_o SHALL hold between beats.

REQ-010 done_o SHALL be 1 for exactly the one cycle in DONE.
- This is the same cycle as the final data_vld_o.
- For num_trans==0 it is the cycle after start, with no AR issued.

REQ-011 An early RLAST SHALL end the burst, and the remaining-word count SHALL be reduced by the beats actually received.

Reset
REQ-012 When rstn=0, the block SHALL go to IDLE asynchronously and zero every output, counter and register; the first AR after reset SHALL come only from a new start_dma.

REQ-013 Reset mid-burst SHALL abort the transfer with no done_o.

Structure
REQ-014 The shared package SHALL hold the AXI constants:
- BURST_INCR=2'b01.
- MAX_BURST=16.
- BOUNDARY_4K=4096.
- State encodings.

REQ-015 The block SHALL be a single module with no sub-modules; axi_sram_if (AXI slave to SRAM bridge) and sram (hex-preloaded memory) are bench-side models only.

Verification
REQ-016 Directed scenarios the bench SHALL cover:
- Start, num_trans=64, start_addr=0 -> ARs at 0x0/0x40/0x80/0xC0 each with ARLEN=15; 64 data_vld_o pulses with data_cnt_o 0..63 and data matching the memory image; one done_o.
- num_trans=20, start_addr=0x100 -> ARLEN=15 at 0x100, then ARLEN=3 at 0x140; 20 words; done_o.
- start_addr=0xFF0, num_trans=8 -> ARLEN=3 at 0xFF0, then ARLEN=3 at 0x1000.
- num_trans=0 -> done_o the next cycle, ARVALID never asserted.
- ARREADY held low 5 cycles, RVALID toggled -> address stable, no lost or duplicate words; a start pulse issued during DATA is ignored.
- rstn low during the second burst -> all outputs 0, no done_o; a new start afterwards completes normally.
